mem_access_unit: RTL

- Initiator-side load/store controller for the byte-addressed 16-bit data memory of the multi-cycle core.
- Takes one access request from the datapath control FSM and sequences the memory strobes MemRead, MemWrite, CTRLBW and CTRLM.
- Returns load data, completion and an error flag to the core.
- Implements byte stores as read-modify-write, because the memory always writes 16 bits: Address gets bits 7:0, Address+1 gets bits 15:8.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store controller: state encoding,
// word width, default memory size and the address range check.
package mem_access_unit_pkg;

    localparam int unsigned WORD_W        = 16;
    localparam int unsigned MEM_BYTES_DEF = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Out of range if the first byte is past the end, or if a second byte
    // is touched (pair=1) and it is past the end. One extra bit stops
    // Addr+1 wrapping at 0xFFFF.
    function automatic logic addr_err(input word_t addr, input logic pair,
                                      input int unsigned mem_bytes);
        logic [WORD_W:0] lim;
        logic [WORD_W:0] a0;
        logic [WORD_W:0] a1;
        lim = (WORD_W+1)'(mem_bytes);
        a0  = {1'b0, addr};
        a1  = a0 + 1'b1;
        return (a0 >= lim) || (pair && (a1 >= lim));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response and data-memory bus of the load/store controller.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    // core side
    logic  Req;
    logic  Store;
    logic  ByteOp;
    logic  SignExt;
    word_t Addr;
    word_t StoreData;
    logic  Busy;
    logic  Done;
    logic  Err;
    word_t LoadData;
    // memory side
    word_t MemAddr;
    logic  MemRead;
    logic  MemWrite;
    logic  CTRLBW;
    logic  CTRLM;
    word_t MemWData;
    word_t MemData;

    // view of the controller itself
    modport slave (
        input  Req, Store, ByteOp, SignExt, Addr, StoreData, MemData,
        output Busy, Done, Err, LoadData,
        output MemAddr, MemRead, MemWrite, CTRLBW, CTRLM, MemWData
    );

    // view of the core plus memory around the controller
    modport master (
        output Req, Store, ByteOp, SignExt, Addr, StoreData, MemData,
        input  Busy, Done, Err, LoadData,
        input  MemAddr, MemRead, MemWrite, CTRLBW, CTRLM, MemWData
    );

endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for the byte-addressed 16-bit data memory.
// Byte stores are read-modify-write because the memory always writes a word.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    mem_access_unit_if.slave   bus
);

    localparam int unsigned    CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    state_e           state_q, state_d;
    logic             store_q, store_d;
    logic             byte_q,  byte_d;
    logic             sext_q,  sext_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    word_t            addr_q,  addr_d;
    word_t            sdata_q, sdata_d;
    word_t            rbuf_q,  rbuf_d;
    word_t            load_q,  load_d;

    logic             range_err;
    logic             ctrlbw;

    assign range_err = addr_err(bus.Addr, ~bus.ByteOp | bus.Store, MEM_BYTES);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            byte_q  <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            rbuf_q  <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            byte_q  <= byte_d;
            sext_q  <= sext_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            rbuf_q  <= rbuf_d;
            load_q  <= load_d;
        end
    end

    // Next-state: accept in IDLE, count read cycles, route byte stores to WR
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        byte_d  = byte_q;
        sext_d  = sext_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        rbuf_d  = rbuf_q;
        load_d  = load_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Req) begin
                    store_d = bus.Store;
                    byte_d  = bus.ByteOp;
                    sext_d  = bus.SignExt;
                    addr_d  = bus.Addr;
                    sdata_d = bus.StoreData;
                    err_d   = range_err;
                    cnt_d   = '0;
                    if (range_err)
                        state_d = ST_DONE;
                    else if (bus.Store && !bus.ByteOp)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_q == CNT_LAST) begin
                    // rbuf and LoadData load together so the result is
                    // already visible while Done is high
                    rbuf_d = bus.MemData;
                    if (store_q) begin
                        state_d = ST_WR;
                    end else begin
                        load_d  = bus.MemData;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ctrlbw        = (state_q == ST_RD) & byte_q & ~store_q;

    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Done      = (state_q == ST_DONE);
    assign bus.Err       = err_q;
    assign bus.LoadData  = load_q;
    assign bus.MemAddr   = addr_q;
    assign bus.MemRead   = (state_q == ST_RD);
    assign bus.MemWrite  = (state_q == ST_WR);
    assign bus.CTRLBW    = ctrlbw;
    assign bus.CTRLM     = ctrlbw & sext_q;
    // byte store rewrites the upper byte with what was just read
    assign bus.MemWData  = byte_q ? {rbuf_q[15:8], sdata_q[7:0]} : sdata_q;

endmodule
